// File: rtl/machina_pkg.sv
// Shared types and constants for the product arbiter slice.
package machina_pkg;

  localparam int ARG_W = 8;
  localparam int RES_W = 16;

  typedef logic [ARG_W-1:0] arg_t;
  typedef logic [RES_W-1:0] res_t;

  // Raw encodings, usable where an enum type cannot be carried.
  localparam logic [2:0] NOENUM_IDLE = 3'd0;
  localparam logic [2:0] NOENUM_ARG  = 3'd1;
  localparam logic [2:0] NOENUM_RES  = 3'd2;
  localparam logic [2:0] NOENUM_ERR  = 3'd3;
  localparam logic [2:0] NOENUM_PRP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = NOENUM_IDLE,
    ARG  = NOENUM_ARG,
    RES  = NOENUM_RES,
    ERR  = NOENUM_ERR,
    PRP  = NOENUM_PRP
  } state_t;

  function automatic int idx_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first asserted request at or above pointer, wrapping.
module rr_select
  import machina_pkg::*;
#(
  parameter int R  = 4,
  parameter int OW = idx_w(R)
) (
  input  logic [R-1:0]  req,
  input  logic [OW-1:0] pointer,
  output logic [OW-1:0] index,
  output logic          found
);

  // Scan from the far end so the candidate closest to pointer wins last.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = R - 1; i >= 0; i--) begin
      if (req[(int'(pointer) + i) % R]) begin
        found = 1'b1;
        index = OW'((int'(pointer) + i) % R);
      end
    end
  end

endmodule

// File: rtl/product_arbiter.sv
// Shares one product unit among R requesters, one whole transaction per grant.
//
// state | meaning
// IDLE  | no owner; grant the round-robin winner of argument_valid
// ARG   | argument channel routed owner -> unit
// RES   | result channel routed unit -> owner
// ERR   | error channel routed owner -> unit (train only)
// PRP   | propagate channel routed unit -> owner (train only)
module product_arbiter
  import machina_pkg::*;
#(
  parameter int R  = 4,
  parameter int N  = 2,
  parameter int OW = idx_w(R)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [R-1:0]                  req_train,
  input  logic [R-1:0]                  req_argument_valid,
  input  logic [R-1:0][N*ARG_W-1:0]     req_argument_data,
  output logic [R-1:0]                  req_argument_ready,
  output logic [R-1:0]                  req_result_valid,
  output res_t                          req_result_data,
  input  logic [R-1:0]                  req_result_ready,
  input  logic [R-1:0]                  req_error_valid,
  input  logic [R-1:0][RES_W-1:0]       req_error_data,
  output logic [R-1:0]                  req_error_ready,
  output logic [R-1:0]                  req_propagate_valid,
  output logic [N*RES_W-1:0]            req_propagate_data,
  input  logic [R-1:0]                  req_propagate_ready,
  output logic                          unit_train,
  output logic                          unit_argument_valid,
  output logic [N*ARG_W-1:0]            unit_argument_data,
  input  logic                          unit_argument_ready,
  input  logic                          unit_result_valid,
  input  res_t                          unit_result_data,
  output logic                          unit_result_ready,
  output logic                          unit_error_valid,
  output res_t                          unit_error_data,
  input  logic                          unit_error_ready,
  input  logic                          unit_propagate_valid,
  input  logic [N*RES_W-1:0]            unit_propagate_data,
  output logic                          unit_propagate_ready,
  output logic [OW-1:0]                 owner,
  output logic                          busy
);

  state_t          state;
  logic [OW-1:0]   pointer;
  logic [OW-1:0]   next_pointer;
  logic [OW-1:0]   sel_index;
  logic            sel_found;

  rr_select #(.R(R), .OW(OW)) u_rr_select (
    .req     (req_argument_valid),
    .pointer (pointer),
    .index   (sel_index),
    .found   (sel_found)
  );

  assign next_pointer = (owner == OW'(R - 1)) ? '0 : owner + 1'b1;
  assign busy         = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      pointer    <= '0;
      unit_train <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            owner      <= sel_index;
            unit_train <= req_train[sel_index];
            state      <= ARG;
          end
        end
        ARG: begin
          if (unit_argument_valid && unit_argument_ready) state <= RES;
        end
        RES: begin
          if (unit_result_valid && unit_result_ready) begin
            if (unit_train) begin
              state <= ERR;
            end else begin
              state   <= IDLE;
              pointer <= next_pointer;
            end
          end
        end
        ERR: begin
          if (unit_error_valid && unit_error_ready) state <= PRP;
        end
        PRP: begin
          if (unit_propagate_valid && unit_propagate_ready) begin
            state   <= IDLE;
            pointer <= next_pointer;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data buses follow owner unconditionally; only valid/ready are gated by state.
  always_comb begin
    req_argument_ready   = '0;
    req_result_valid     = '0;
    req_error_ready      = '0;
    req_propagate_valid  = '0;
    unit_argument_valid  = 1'b0;
    unit_result_ready    = 1'b0;
    unit_error_valid     = 1'b0;
    unit_propagate_ready = 1'b0;
    unit_argument_data   = req_argument_data[owner];
    unit_error_data      = req_error_data[owner];
    req_result_data      = unit_result_data;
    req_propagate_data   = unit_propagate_data;
    case (state)
      ARG: begin
        unit_argument_valid       = req_argument_valid[owner];
        req_argument_ready[owner] = unit_argument_ready;
      end
      RES: begin
        req_result_valid[owner] = unit_result_valid;
        unit_result_ready       = req_result_ready[owner];
      end
      ERR: begin
        unit_error_valid       = req_error_valid[owner];
        req_error_ready[owner] = unit_error_ready;
      end
      PRP: begin
        req_propagate_valid[owner] = unit_propagate_valid;
        unit_propagate_ready       = req_propagate_ready[owner];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/product_arbiter.md
# product_arbiter

Round-robin arbiter that shares one `product` neuron among `R` requesters. It grants the unit to one requester for a whole transaction: argument in, result out, and, when training, error in and propagate out. It routes every handshake channel between the owner and the unit. It sits between the layer sequencing logic and a single `product` instance, so several logical neurons can be time-multiplexed onto one multiply-accumulate datapath.

## Interface
- `R`, 4, number of requesters (≥1)
- `N`, 2, product fan-in, forwarded to argument/propagate widths
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low
- `req_train` in R: per-requester train flag, sampled at grant
- `req_argument_valid` in R / `req_argument_data` in R×N×8 / `req_argument_ready` out R
- `req_result_valid` out R / `req_result_data` out 16 (broadcast) / `req_result_ready` in R
- `req_error_valid` in R / `req_error_data` in R×16 / `req_error_ready` out R
- `req_propagate_valid` out R / `req_propagate_data` out N×16 (broadcast) / `req_propagate_ready` in R
- `unit_train` out 1; `unit_argument_*`, `unit_result_*`, `unit_error_*`, `unit_propagate_*`: mirror of the `product` ports, opposite direction
- `owner` out clog2(R) (min 1): current grantee; `busy` out 1

## Operation
- States: IDLE, ARG, RES, ERR, PRP.
- IDLE: if any `req_argument_valid`, register the round-robin winner (search from `pointer` upward, wrapping) into `owner`, latch `req_train[owner]` into `unit_train`, go to ARG. Otherwise stay.
- ARG: `unit_argument_valid/data` = owner's; `req_argument_ready[owner]` = `unit_argument_ready`. On handshake go to RES.
- RES: `req_result_valid[owner]` = `unit_result_valid`; `unit_result_ready` = `req_result_ready[owner]`. On handshake go to ERR if latched train, else IDLE.
- ERR: error channel routed owner→unit. On handshake go to PRP.
- PRP: propagate channel routed unit→owner. On handshake go to IDLE.
- On return to IDLE: `pointer` ← (owner+1) mod R; R−1 wraps to 0.
- Non-owners, and all requesters in other states: ready/valid outputs forced 0. Broadcast data is don't-care when valid is 0.
- `unit_train` is constant from grant until return to IDLE; the unit samples it in its RES state.
- The owner must hold `argument_valid` once asserted. The arbiter waits indefinitely in any state; there is no timeout and no pre-emption.
- New requests during a transaction are held off and competed for at the next IDLE.

## Timing
- Grant latency: 1 cycle from `req_argument_valid` (IDLE) to `req_argument_ready` possible (ARG).
- All routing in ARG–PRP is combinational on registered `state`/`owner`, so it adds zero handshake latency.
- Minimum IDLE gap between transactions: 1 cycle.
- Reset values: state IDLE, `pointer` 0, `owner` 0, `unit_train` 0, `busy` 0, every valid/ready output 0.
- Reset assertion mid-transaction: return to IDLE immediately. The integrator drives the unit's reset from the same source. No partial-transaction recovery.
- `busy` = (state ≠ IDLE).

## Structure
- Package `machina_pkg`: state enum (with `NOENUM` localparam fallback), `arg_t`/`res_t` widths, 8-bit argument and 16-bit result constants.
- Sub-module `rr_select`: combinational R-way priority search from `pointer`, outputs index and found flag.
- Registers and channel muxing stay in `product_arbiter`.

## Test plan
- R=4, only req 2 valid, train=0, args {0x10,0x20} → granted after 1 cycle; result delivered only on `req_result_valid[2]`; pointer becomes 3.
- Reqs 0,1,3 valid continuously, train=0 → grant order 0,1,3,0,… with exactly 1 IDLE cycle between transactions.
- Req 1 with train=1, error 0x0100 → unit sees `unit_train`=1 throughout; error reaches the unit; propagate returned to req 1 only; then IDLE.
- Req 3 granted with pointer=3; a transaction then completes → pointer wraps to 0.
- `req_result_ready` held low for 5 cycles → state stays RES; other requesters see ready=0; no grant change.
- `reset` pulsed low during ERR → all outputs 0 asynchronously; state IDLE; next grant starts from req 0.
